serial_paralelo_align: RTL
==========================

SERIAL_PARALELO_ALIGN -- requirements
Module: serial_paralelo_align

Interface
REQ-001 Parameter COM_SYMBOL, default 8'hBC, comma/idle symbol used for byte alignment.
REQ-002 Parameter ALIGN_COUNT, default 4, consecutive aligned COM bytes required to declare alignment; legal range 1..7.
REQ-003 clk_8f  input  1  single bit-rate clock; one serial bit sampled per rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_serial_in  input  1  serial lane from the upstream parallel-to-serial stage, MSB first.
REQ-006 data_out  output  8  last received non-COM data byte, registered.
REQ-007 valid_out  output  1  high while data_out holds a data byte from the most recent byte boundary.
REQ-008 byte_strobe  output  1  one-cycle pulse per completed aligned byte in ACTIVE.
REQ-009 active  output  1  high while the FSM is in ACTIVE.

Function
REQ-010 Every clk_8f edge shall shift: sr <= {sr[6:0], data_serial_in}; the candidate byte is {sr[6:0], data_serial_in}.
REQ-011 A 3-bit bit counter shall increment every cycle, wrapping 7->0; byte boundary = cycle where the counter equals 7.
REQ-012 FSM states: HUNT, COUNT, ACTIVE; reset state HUNT.
REQ-013 HUNT: every cycle, candidate == COM_SYMBOL -> bit counter forced to 0, COM counter = 1, go COUNT (or straight to ACTIVE if ALIGN_COUNT == 1); otherwise stay, bit counter free-running.
REQ-014 COUNT: at each byte boundary, candidate == COM_SYMBOL -> COM counter +1; reaching ALIGN_COUNT -> ACTIVE same edge.
REQ-015 COUNT: at a byte boundary, candidate != COM_SYMBOL -> HUNT, COM counter cleared; no output change.
REQ-016 COUNT/HUNT: data_out, valid_out, byte_strobe held at reset values.
REQ-017 ACTIVE: at each byte boundary byte_strobe = 1 for exactly the following cycle.
REQ-018 ACTIVE, non-COM byte: data_out <= candidate, valid_out <= 1 on the boundary edge (latency 1 clk after 8th bit sampled).
REQ-019 ACTIVE, COM byte: data_out retains previous value, valid_out <= 0.
REQ-020 data_out and valid_out shall be stable for all 8 cycles between boundaries.
REQ-021 ACTIVE is left only by reset; COM bytes in ACTIVE never retrigger alignment.
REQ-022 COM counter shall saturate at ALIGN_COUNT; no wrap.
REQ-023 Simultaneous COM match and counter == 7 in HUNT: the HUNT rule (REQ-013) wins.

Reset
REQ-024 reset low shall immediately clear sr, bit counter, COM counter, data_out (8'h00), valid_out, byte_strobe, active, FSM -> HUNT, independent of clk_8f.
REQ-025 Reset asserted mid-byte or in ACTIVE shall discard the partial byte; after release, alignment restarts from HUNT.
REQ-026 First shift after reset release occurs on the first rising clk_8f edge with reset high.

Structure
REQ-027 Shared package holds COM_SYMBOL default (8'hBC), FSM state encoding (HUNT=2'b00, COUNT=2'b01, ACTIVE=2'b10) and the bit counter width.
REQ-028 One sub-module, com_detector: shift register plus candidate/COM_SYMBOL comparator, outputs candidate[7:0] and com_match.
REQ-029 FSM, counters and output registers reside in serial_paralelo_align.

Verification
REQ-030 Reset low, then 5 COM bytes (8'hBC) at offset 0 -> active rises on edge of 4th COM's 8th bit; valid_out = 0, data_out = 8'h00.
REQ-031 3 random bits, then 4 x 8'hBC, then 8'hA5, 8'h3C -> active set; data_out = 8'hA5 with valid_out = 1 and byte_strobe pulse, then 8'h3C 8 clk later.
REQ-032 3 x 8'hBC then 8'h11 then 4 x 8'hBC -> returns HUNT after 8'h11, active rises only after the later 4 COMs.
REQ-033 ACTIVE, stream 8'h55, 8'hBC, 8'h66 -> data_out 8'h55 (valid 1), 8'h55 (valid 0), 8'h66 (valid 1); byte_strobe pulses every 8 clk.
REQ-034 reset low on bit 4 of a data byte in ACTIVE -> all outputs 0 same cycle, no clock needed; re-alignment needs 4 fresh COMs.
REQ-035 ALIGN_COUNT = 1, single 8'hBC -> active rises on the matching edge.

Source files
------------

// File: rtl/serial_paralelo_align_pkg.sv
// serial_paralelo_align_pkg: shared constants and FSM encoding for the serial byte aligner.
`default_nettype none

package serial_paralelo_align_pkg;

   localparam logic [7:0] COM_SYMBOL_DEFAULT = 8'hBC;
   localparam int         BIT_CNT_W          = 3;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      COUNT  = 2'b01,
      ACTIVE = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_paralelo_align_com_detector.sv
// com_detector: serial shift register plus comparison of the candidate byte against COM_SYMBOL.
`default_nettype none

module com_detector
   import serial_paralelo_align_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEFAULT
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_serial_in,
   output logic [7:0] candidate,
   output logic       com_match
);

   // Only seven history bits are needed; the eighth is the live input bit.
   logic [6:0] sr_q;
   logic [6:0] sr_d;

   always_comb begin
      sr_d = {sr_q[5:0], data_serial_in};
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         sr_q <= 7'd0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign candidate = {sr_q, data_serial_in};
   assign com_match = (candidate == COM_SYMBOL);

endmodule

`default_nettype wire

// File: rtl/serial_paralelo_align.sv
// serial_paralelo_align: locks byte boundaries on a serial lane using repeated COM symbols, then deserializes.
`default_nettype none

module serial_paralelo_align
   import serial_paralelo_align_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL  = COM_SYMBOL_DEFAULT,
   parameter int         ALIGN_COUNT = 4
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       data_serial_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   localparam logic [2:0] ALIGN_CNT = 3'(ALIGN_COUNT);

   logic [7:0]           candidate;
   logic                 com_match;
   logic                 boundary;

   state_t               state_q,   state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]           com_cnt_q, com_cnt_d;
   logic [7:0]           data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 strobe_q,  strobe_d;

   com_detector #(
      .COM_SYMBOL (COM_SYMBOL)
   ) u_com_detector (
      .clk_8f         (clk_8f),
      .reset          (reset),
      .data_serial_in (data_serial_in),
      .candidate      (candidate),
      .com_match      (com_match)
   );

   assign boundary = (bit_cnt_q == '1);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q + 1'b1;
      com_cnt_d = com_cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      strobe_d  = 1'b0;

      case (state_q)
         HUNT: begin
            // A match here defines the byte phase, overriding any counter wrap.
            if (com_match) begin
               bit_cnt_d = '0;
               com_cnt_d = 3'd1;
               state_d   = (ALIGN_COUNT == 1) ? ACTIVE : COUNT;
            end
         end
         COUNT: begin
            if (boundary) begin
               if (com_match) begin
                  if (com_cnt_q < ALIGN_CNT) begin
                     com_cnt_d = com_cnt_q + 3'd1;
                  end
                  if (com_cnt_q + 3'd1 >= ALIGN_CNT) begin
                     state_d = ACTIVE;
                  end
               end else begin
                  com_cnt_d = 3'd0;
                  state_d   = HUNT;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               strobe_d = 1'b1;
               if (com_match) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = candidate;
                  valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state_q   <= HUNT;
         bit_cnt_q <= '0;
         com_cnt_q <= 3'd0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         strobe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         strobe_q  <= strobe_d;
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = (state_q == ACTIVE);

endmodule

`default_nettype wire
